spi_sclk_gen: RTL and testbench
===============================

SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 SHALL have parameter SPI_MAXLEN, default 16, meaning the maximum SCLK pulses per transfer.
REQ-002 SHALL have parameter DIV_W, default 16, meaning the width of the half-period divider.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port div, input, DIV_W bits: SCLK half-period is div+1 clk cycles.
REQ-006 SHALL have port n_pulses, input, $clog2(SPI_MAXLEN)+1 bits: SCLK pulses per transfer, from 0 to SPI_MAXLEN.
REQ-007 SHALL have ports cpol and cpha, input, 1 bit each: the SPI mode.
REQ-008 SHALL have port start, input, 1 bit: transfer request.
REQ-009 SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port sclk, output, 1 bit: registered SPI clock.
REQ-012 SHALL have ports sample_stb and shift_stb, output, 1 bit each: one-cycle data strobes.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and RUN.
REQ-014 In IDLE, start=1 with n_pulses!=0 SHALL latch div, n_pulses, cpol and cpha, clear the half-period counter and edge counter, and enter RUN; busy=1 from the next cycle.
REQ-015 In IDLE, start=1 with n_pulses==0 SHALL produce done=1 on the next cycle, with no SCLK edges and busy staying 0.
REQ-016 start while in RUN SHALL be ignored; input changes during RUN SHALL have no effect.
REQ-017 In RUN, the counter SHALL count 0..div_q; at div_q it SHALL wrap to 0 and toggle sclk; the first toggle is visible div_q+1 cycles after busy rises.
REQ-018 The edge counter SHALL be wide enough for 2*SPI_MAXLEN; a transfer is exactly 2*n_q toggles, and sclk ends at cpol_q.
REQ-019 The final toggle SHALL register done=1 and busy=0 together, returning the FSM to IDLE; done SHALL last exactly one cycle.
REQ-020 Odd toggles are leading edges and even toggles are trailing edges; strobes SHALL assert in the same cycle the corresponding sclk value is registered.
REQ-021 With cpha=0: sample_stb SHALL pulse on every leading edge (n pulses), and shift_stb SHALL pulse on trailing edges 1..n-1 (the final trailing edge is suppressed).
REQ-022 With cpha=1: shift_stb SHALL pulse on every leading edge (n pulses), and sample_stb SHALL pulse on every trailing edge (n pulses).
REQ-023 In IDLE, sclk SHALL equal the registered cpol input, and both strobes SHALL be 0.
REQ-024 div=0 SHALL give sclk = clk/2 with no idle cycles between edges.
REQ-025 A new start is accepted in the cycle after done; back-to-back transfers SHALL be supported with no extra gap.

Reset
REQ-026 rst=1 SHALL force IDLE, with sclk=0, busy=0, done=0, sample_stb=0, shift_stb=0, and both counters 0.
REQ-027 rst asserted mid-transfer SHALL abandon the transfer without issuing done.

Configuration
REQ-028 Macro SPI_SCLK_GEN_ABORT_EN, when defined, SHALL add input port abort (1 bit).
REQ-029 With the macro defined, abort=1 in RUN SHALL return the FSM to IDLE on the next cycle, with sclk=cpol_q, done=1 for one cycle, and no further strobes; abort=1 in IDLE SHALL be ignored.
REQ-030 With the macro undefined, the abort port and its logic SHALL be absent, and transfers always complete.

Structure
REQ-031 Package spi_pkg SHALL hold the FSM state enum (IDLE, RUN), the SPI_MAXLEN default, and the width constants and functions for the pulse and edge counters.
REQ-032 The half-period counter SHALL be sub-module spi_half_period_cnt (inputs clr, en, div; output tick), instantiated once.

Verification
REQ-033 div=0, n=8, cpol=0, cpha=0 -> 16 toggles; busy for 16 cycles; 8 sample_stb and 7 shift_stb; done one cycle; sclk ends at 0.
REQ-034 div=3, n=2, cpol=1, cpha=1 -> first toggle 4 cycles after busy rises; sclk goes 1->0->1->0->1 with a half-period of 4; 2 shift_stb and 2 sample_stb.
REQ-035 n=0 with start -> done the next cycle; sclk unchanged; busy stays 0.
REQ-036 n=16, div=1, with start re-asserted in the cycle after done -> second transfer begins with no gap; start pulses issued mid-transfer are ignored.
REQ-037 rst asserted at toggle 5 of a 16-toggle transfer -> next cycle IDLE with sclk=0, no done; a subsequent start runs normally.
REQ-038 (SPI_SCLK_GEN_ABORT_EN) abort at toggle 3, cpol=1 -> next cycle sclk=1, done=1, busy=0, no further strobes.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type, default transfer length and counter width helpers for spi_sclk_gen.
package spi_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int SPI_MAXLEN_DEF = 16;
  function automatic int pulse_w(input int maxlen);
    return $clog2(maxlen) + 1;
  endfunction
  function automatic int edge_w(input int maxlen);
    return pulse_w(maxlen) + 1;
  endfunction
endpackage

// File: rtl/spi_half_period_cnt.sv
// spi_half_period_cnt: counts 0..div and pulses tick on the wrap cycle.
module spi_half_period_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = en && cnt == div;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SPI SCLK generator with mode-aware sample/shift strobes.
// Define SPI_SCLK_GEN_ABORT_EN to add an abort input that ends a running transfer early.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int SPI_MAXLEN = SPI_MAXLEN_DEF,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              div,
  input  logic [$clog2(SPI_MAXLEN):0]   n_pulses,
  input  logic                          cpol,
  input  logic                          cpha,
  input  logic                          start,
`ifdef SPI_SCLK_GEN_ABORT_EN
  input  logic                          abort,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          sclk,
  output logic                          sample_stb,
  output logic                          shift_stb
);
  localparam int PW = pulse_w(SPI_MAXLEN);
  localparam int EW = edge_w(SPI_MAXLEN);
  state_t state, nxt;
  logic [DIV_W-1:0] div_q;
  logic [PW-1:0] n_q;
  logic cpol_q, cpha_q;
  logic [EW-1:0] ecnt, k;
  logic tick, accept, last, lead, abort_run;
  assign accept = state == IDLE && start && n_pulses != '0;
`ifdef SPI_SCLK_GEN_ABORT_EN
  assign abort_run = state == RUN && abort;
`else
  assign abort_run = 1'b0;
`endif
  assign k = ecnt + EW'(1);
  assign last = k == {n_q, 1'b0};
  assign lead = k[0];
  assign busy = state == RUN;
  spi_half_period_cnt #(.DIV_W(DIV_W)) u_hp (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (busy && !abort_run),
    .div (div_q),
    .tick(tick)
  );
  always_comb
    nxt = accept ? RUN : (busy && (abort_run || (tick && last))) ? IDLE : state;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  // Odd toggles (k[0]=1) are leading edges; the final trailing shift is dropped in mode cpha=0.
  always_ff @(posedge clk)
    if (rst) begin
      sclk       <= 1'b0;
      done       <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      ecnt       <= '0;
      div_q      <= '0;
      n_q        <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
    end else begin
      done       <= (state == IDLE && start && n_pulses == '0) || abort_run || (busy && tick && last);
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      if (state == IDLE) begin
        sclk <= cpol;
        ecnt <= '0;
        if (accept) begin
          div_q  <= div;
          n_q    <= n_pulses;
          cpol_q <= cpol;
          cpha_q <= cpha;
        end
      end else if (abort_run) begin
        sclk <= cpol_q;
      end else if (tick) begin
        sclk       <= ~sclk;
        ecnt       <= k;
        sample_stb <= lead ? !cpha_q : cpha_q;
        shift_stb  <= lead ? cpha_q : !cpha_q && !last;
      end
    end
endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: table-driven checks of spi_sclk_gen plus reset, back-to-back and abort sequences.
module tb_spi_sclk_gen;
  logic clk = 0, rst = 1, cpol = 0, cpha = 0, start = 0;
  logic [15:0] div = 0;
  logic [4:0] n_pulses = 0;
  logic busy, done, sclk, sample_stb, shift_stb;
`ifdef SPI_SCLK_GEN_ABORT_EN
  logic abort = 0;
`endif
  spi_sclk_gen dut (
    .clk(clk), .rst(rst), .div(div), .n_pulses(n_pulses), .cpol(cpol), .cpha(cpha),
    .start(start),
`ifdef SPI_SCLK_GEN_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .sclk(sclk), .sample_stb(sample_stb), .shift_stb(shift_stb)
  );
  always #5 clk = ~clk;

  typedef struct {
    int d, n;
    bit cp, ch;
    int e_tog, e_busy, e_first, e_samp, e_shift;
  } vec_t;
  vec_t tbl[7];
  int total = 0, bad = 0;
  int tog, busyc, first, samp, shft, stberr, interr, endsclk, timeout, b0, d0, s0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Drive one transfer from a negedge and observe it until done; returns at the done negedge.
  task automatic go(input int d, input int n, input bit cp, input bit ch, input bit junk);
    int t, last_t;
    logic ps, tc;
    div = 16'(d); n_pulses = 5'(n); cpol = cp; cpha = ch; start = 1;
    @(negedge clk);
    start = 0;
    tog = 0; busyc = 0; first = -1; samp = 0; shft = 0; stberr = 0; interr = 0; timeout = 0; last_t = 0;
    b0 = int'(busy); d0 = int'(done); s0 = int'(sclk); ps = sclk;
    if (n == 0) return;
    t = 0;
    while (1) begin
      if (busy) busyc++;
      tc = sclk !== ps;
      if (tc) begin
        tog++;
        if (first < 0) first = t;
        else if (t - last_t != d + 1) interr++;
        last_t = t;
      end
      if (sample_stb) begin samp++; if (!(tc && ((sclk != cp) == !ch))) stberr++; end
      if (shift_stb) begin shft++; if (!(tc && ((sclk != cp) == ch))) stberr++; end
      ps = sclk;
      if (done || t >= 5000) break;
      if (junk) begin
        start = 1'($urandom); div = 16'($urandom); n_pulses = 5'($urandom_range(0, 16));
        cpol = 1'($urandom); cpha = 1'($urandom);
      end
      @(negedge clk);
      t++;
    end
    timeout = int'(!done);
    endsclk = int'(sclk);
    start = 0; div = 16'(d); n_pulses = 5'(n); cpol = cp; cpha = ch;
  endtask

  task automatic chk_xfer(input string nm, input vec_t v);
    if (v.n == 0) begin
      chk({nm, " done0"}, d0, 1);
      chk({nm, " busy0"}, b0, 0);
      chk({nm, " sclk0"}, s0, int'(v.cp));
    end else begin
      chk({nm, " busy_rise"}, b0, 1);
      chk({nm, " sclk_start"}, s0, int'(v.cp));
      chk({nm, " timeout"}, timeout, 0);
      chk({nm, " toggles"}, tog, v.e_tog);
      chk({nm, " busy_cycles"}, busyc, v.e_busy);
      chk({nm, " first_toggle"}, first, v.e_first);
      chk({nm, " half_period"}, interr, 0);
      chk({nm, " sample_cnt"}, samp, v.e_samp);
      chk({nm, " shift_cnt"}, shft, v.e_shift);
      chk({nm, " strobe_edge"}, stberr, 0);
      chk({nm, " sclk_end"}, endsclk, int'(v.cp));
    end
  endtask

  initial begin
    int dn;
    logic ps;
    tbl[0] = '{0, 8, 0, 0, 16, 16, 1, 8, 7};
    tbl[1] = '{3, 2, 1, 1, 4, 16, 4, 2, 2};
    tbl[2] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 16, 1, 0, 32, 64, 2, 16, 15};
    tbl[4] = '{2, 1, 0, 1, 2, 6, 3, 1, 1};
    tbl[5] = '{0, 1, 1, 0, 2, 2, 1, 1, 0};
    tbl[6] = '{4, 3, 0, 0, 6, 30, 5, 3, 2};
    repeat (3) @(negedge clk);
    chk("rst sclk", int'(sclk), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst strobes", int'(sample_stb | shift_stb), 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      go(tbl[i].d, tbl[i].n, tbl[i].cp, tbl[i].ch, bit'(i % 2));
      chk_xfer($sformatf("vec%0d", i), tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d done_once", i), int'(done), 0);
      chk($sformatf("vec%0d idle_busy", i), int'(busy), 0);
      chk($sformatf("vec%0d idle_sclk", i), int'(sclk), int'(tbl[i].cp));
    end
    go(1, 16, 0, 0, 1);
    chk_xfer("b2b_a", '{1, 16, 0, 0, 32, 64, 2, 16, 15});
    go(1, 16, 1, 1, 1);
    chk("b2b_b done_low", d0, 0);
    chk_xfer("b2b_b", '{1, 16, 1, 1, 32, 64, 2, 16, 16});
    @(negedge clk);
    div = 0; n_pulses = 8; cpol = 0; cpha = 0; start = 1;
    @(negedge clk);
    start = 0; ps = sclk; tog = 0;
    for (int t = 0; t < 100 && tog < 5; t++) begin
      @(negedge clk);
      if (sclk !== ps) tog++;
      ps = sclk;
    end
    chk("rst_mid toggles", tog, 5);
    chk("rst_mid sclk_high", int'(sclk), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid busy", int'(busy), 0);
    chk("rst_mid sclk", int'(sclk), 0);
    chk("rst_mid done", int'(done), 0);
    dn = 0;
    repeat (20) begin @(negedge clk); dn += int'(done | busy | sample_stb | shift_stb); end
    chk("rst_mid quiet", dn, 0);
    go(0, 8, 0, 0, 0);
    chk_xfer("after_rst", tbl[0]);
`ifdef SPI_SCLK_GEN_ABORT_EN
    @(negedge clk);
    div = 1; n_pulses = 4; cpol = 1; cpha = 0; start = 1;
    @(negedge clk);
    start = 0; ps = sclk; tog = 0;
    for (int t = 0; t < 100 && tog < 3; t++) begin
      @(negedge clk);
      if (sclk !== ps) tog++;
      ps = sclk;
    end
    chk("abort toggles", tog, 3);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort sclk", int'(sclk), 1);
    chk("abort done", int'(done), 1);
    chk("abort busy", int'(busy), 0);
    chk("abort strobes", int'(sample_stb | shift_stb), 0);
    dn = 0;
    repeat (8) begin @(negedge clk); dn += int'(done | busy | sample_stb | shift_stb); end
    chk("abort quiet", dn, 0);
    abort = 1;
    repeat (2) @(negedge clk);
    abort = 0;
    chk("abort_idle done", int'(done), 0);
    chk("abort_idle busy", int'(busy), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
